// File: rtl/fnn_pkg.sv
// Shared constants, FSM state type and score post-processing for the output layer.
package fnn_pkg;

    localparam int unsigned N_IN  = 30;
    localparam int unsigned N_OUT = 10;
    localparam int unsigned DW    = 8;
    localparam int unsigned WW    = 8;

    // Wide working width so one helper serves any accumulator width up to 64 bits.
    localparam int unsigned SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ReLU, arithmetic right shift, then clamp to an unsigned dw-bit range.
    function automatic logic [31:0] sat_relu(input logic signed [SAT_W-1:0] r,
                                             input int unsigned             shift,
                                             input int unsigned             dw);
        logic signed [SAT_W-1:0] s;
        logic        [SAT_W-1:0] maxv;
        logic        [31:0]      res;
        maxv = (SAT_W'(1) << dw) - SAT_W'(1);
        s    = r >>> shift;
        if (r[SAT_W-1]) begin
            res = '0;
        end else if ($unsigned(s) > maxv) begin
            res = 32'(maxv);
        end else begin
            res = 32'(s);
        end
        return res;
    endfunction

endpackage

// File: rtl/output_layer_acc_mac_unit.sv
// Unsigned-activation by signed-weight multiply with a clearable accumulator.
module mac_unit #(
    parameter int unsigned DW   = 8,
    parameter int unsigned WW   = 8,
    parameter int unsigned ACCW = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [DW-1:0]          x,
    input  logic [WW-1:0]          w,
    output logic signed [ACCW-1:0] acc
);

    localparam int unsigned PW = DW + WW + 1;

    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] ws;
    logic signed [PW-1:0] prod;

    // Activation gets a zero sign bit; the product always fits in PW bits.
    assign xs   = PW'($signed({1'b0, x}));
    assign ws   = PW'($signed(w));
    assign prod = xs * ws;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/output_layer_acc.sv
// Output-layer MAC engine: streams weights from a synchronous ROM, one multiply
// per cycle, and packs ReLU-saturated class scores for the argmax stage.
module output_layer_acc #(
    parameter int unsigned N_IN  = fnn_pkg::N_IN,
    parameter int unsigned N_OUT = fnn_pkg::N_OUT,
    parameter int unsigned DW    = fnn_pkg::DW,
    parameter int unsigned WW    = fnn_pkg::WW,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned ACCW  = DW + WW + $clog2(N_IN + 1) + 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [N_IN*DW-1:0]                          x_in,
    output logic [$clog2(N_OUT*(N_IN+1))-1:0]           w_addr,
    output logic                                        w_en,
    input  logic [WW-1:0]                               w_data,
    output logic                                        busy,
    output logic                                        done,
    output logic [N_OUT*DW-1:0]                         scores,
    output logic                                        scores_valid
);

    import fnn_pkg::*;

    localparam int unsigned M  = N_OUT * (N_IN + 1);
    localparam int unsigned AW = $clog2(M);
    localparam int unsigned IW = $clog2(N_IN + 1);
    localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t state;
    state_t state_nx;
    logic   accept;
    logic   last_issue;

    logic [IW-1:0]      i_cnt;
    logic [JW-1:0]      j_cnt;
    logic               rd_vld;
    logic [IW-1:0]      rd_i;
    logic [JW-1:0]      rd_j;
    logic [N_IN*DW-1:0] x_sh;

    logic                   is_bias;
    logic                   mac_en;
    logic                   mac_clr;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] r_sum;
    logic [DW-1:0]          relu_q;

    // Next-state decode
    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        last_issue = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end
            end
            RUN: begin
                if (w_addr == AW'(M - 1)) begin
                    state_nx   = DRAIN;
                    last_issue = 1'b1;
                end
            end
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Returned ROM word: weight words feed the MAC, the bias word finishes a neuron.
    assign is_bias = (rd_i == IW'(N_IN));
    assign mac_en  = rd_vld && !is_bias;
    assign mac_clr = accept || (rd_vld && is_bias);
    assign r_sum   = acc + ACCW'($signed(w_data));
    assign relu_q  = DW'(sat_relu(SAT_W'(r_sum), SHIFT, DW));

    mac_unit #(
        .DW   (DW),
        .WW   (WW),
        .ACCW (ACCW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .x   (x_sh[DW-1:0]),
        .w   (w_data),
        .acc (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            w_en         <= 1'b0;
            w_addr       <= '0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            rd_vld       <= 1'b0;
            rd_i         <= '0;
            rd_j         <= '0;
            x_sh         <= '0;
            scores       <= '0;
            scores_valid <= 1'b0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx == RUN) || (state_nx == DRAIN);
            done   <= (state_nx == DONE);
            w_en   <= (state_nx == RUN);
            rd_vld <= (state == RUN);
            rd_i   <= i_cnt;
            rd_j   <= j_cnt;
            if (accept) begin
                w_addr       <= '0;
                i_cnt        <= '0;
                j_cnt        <= '0;
                x_sh         <= x_in;
                scores_valid <= 1'b0;
            end else begin
                if ((state == RUN) && !last_issue) begin
                    w_addr <= w_addr + AW'(1);
                    if (i_cnt == IW'(N_IN)) begin
                        i_cnt <= '0;
                        j_cnt <= j_cnt + JW'(1);
                    end else begin
                        i_cnt <= i_cnt + IW'(1);
                    end
                end
                // Rotate so the next activation is always in the low slot.
                if (mac_en) begin
                    x_sh <= {x_sh[DW-1:0], x_sh[N_IN*DW-1:DW]};
                end
                if (rd_vld && is_bias) begin
                    scores[DW*int'(rd_j) +: DW] <= relu_q;
                end
                if (state_nx == DONE) begin
                    scores_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_layer_acc.sv
// Randomised and directed check of output_layer_acc (N_IN=3, N_OUT=10) at SHIFT 0 and 2.
module tb_output_layer_acc;

    localparam int NI = 3;
    localparam int NO = 10;
    localparam int M  = NO * (NI + 1);
    localparam int AW = $clog2(M);
    localparam int BW = NO * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start;
    logic [NI*8-1:0] x_in;

    logic [AW-1:0] w_addr0, w_addr1;
    logic          w_en0, w_en1, busy0, busy1, done0, done1, sv0, sv1;
    logic [7:0]    wd0, wd1;
    logic [BW-1:0] scores0, scores1;

    logic signed [7:0] rom [M];

    output_layer_acc #(.N_IN(NI), .N_OUT(NO), .DW(8), .WW(8), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in),
        .w_addr(w_addr0), .w_en(w_en0), .w_data(wd0),
        .busy(busy0), .done(done0), .scores(scores0), .scores_valid(sv0)
    );

    output_layer_acc #(.N_IN(NI), .N_OUT(NO), .DW(8), .WW(8), .SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in),
        .w_addr(w_addr1), .w_en(w_en1), .w_data(wd1),
        .busy(busy1), .done(done1), .scores(scores1), .scores_valid(sv1)
    );

    // Synchronous ROMs, one per DUT
    always @(posedge clk) begin
        if (w_en0) wd0 <= rom[int'(w_addr0)];
        if (w_en1) wd1 <= rom[int'(w_addr1)];
    end

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int score(input logic [NI*8-1:0] xb, input int j, input int sh);
        int acc = 0;
        int r;
        for (int i = 0; i < NI; i++) acc += int'(xb[8*i +: 8]) * int'(rom[j*(NI+1)+i]);
        r = acc + int'(rom[j*(NI+1)+NI]);
        if (r < 0) return 0;
        r = r >>> sh;
        if (r > 255) return 255;
        return r;
    endfunction

    function automatic int argmax(input logic [BW-1:0] s);
        int best = 0;
        for (int j = 1; j < NO; j++) if (s[8*j +: 8] > s[8*best +: 8]) best = j;
        return best;
    endfunction

    // Reference model: t is the cycle number within a run (1..M+2), -1 when idle.
    int            t = -1;
    bit            sv_m = 1'b0;
    logic [BW-1:0] cur0 = '0;
    logic [BW-1:0] cur1 = '0;
    int            new0 [NO];
    int            new1 [NO];

    always @(posedge clk) begin
        if (rst) begin
            t    <= -1;
            sv_m <= 1'b0;
            cur0 <= '0;
            cur1 <= '0;
        end else if (t == -1) begin
            if (start) begin
                t    <= 1;
                sv_m <= 1'b0;
                for (int j = 0; j < NO; j++) begin
                    new0[j] <= score(x_in, j, 0);
                    new1[j] <= score(x_in, j, 2);
                end
            end
        end else if (t == M + 2) begin
            t <= -1;
        end else begin
            t <= t + 1;
            // Neuron j's bias word is consumed two cycles after its issue cycle.
            for (int j = 0; j < NO; j++) begin
                if (t + 1 == j*(NI+1) + NI + 3) begin
                    cur0[8*j +: 8] <= 8'(new0[j]);
                    cur1[8*j +: 8] <= 8'(new1[j]);
                end
            end
            if (t + 1 == M + 2) sv_m <= 1'b1;
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_wen, e_done;
        if (chk_en) begin
            e_busy = (t >= 1) && (t <= M + 1);
            e_wen  = (t >= 1) && (t <= M);
            e_done = (t == M + 2);
            chk("d0.busy", BW'(busy0), BW'(e_busy));
            chk("d1.busy", BW'(busy1), BW'(e_busy));
            chk("d0.w_en", BW'(w_en0), BW'(e_wen));
            chk("d1.w_en", BW'(w_en1), BW'(e_wen));
            chk("d0.done", BW'(done0), BW'(e_done));
            chk("d1.done", BW'(done1), BW'(e_done));
            chk("d0.scores_valid", BW'(sv0), BW'(sv_m));
            chk("d1.scores_valid", BW'(sv1), BW'(sv_m));
            chk("d0.scores", scores0, cur0);
            chk("d1.scores", scores1, cur1);
            if (e_wen) begin
                chk("d0.w_addr", BW'(w_addr0), BW'(t - 1));
                chk("d1.w_addr", BW'(w_addr1), BW'(t - 1));
            end
        end
    end

    int done_cyc;
    int wen_cnt;

    // One run: start in cycle 0, optional protocol pulses, optional reset in cycle rcyc.
    task automatic do_run(input bit proto, input int rcyc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        done_cyc = -1;
        wen_cnt  = 0;
        for (int c = 1; c <= M + 4; c++) begin
            if (done0 && done_cyc < 0) done_cyc = c;
            if (w_en0) wen_cnt++;
            if (rcyc != 0 && c == rcyc + 1) begin
                chk("rst_mid.busy", BW'(busy0), '0);
                chk("rst_mid.w_en", BW'(w_en0), '0);
                chk("rst_mid.w_addr", BW'(w_addr0), '0);
                chk("rst_mid.scores", scores0, '0);
            end
            start = proto && (c == 5 || c == 20 || c == 42);
            rst   = (rcyc != 0) && (c == rcyc);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic load_uniform(input int w, input int b);
        for (int k = 0; k < M; k++) rom[k] = 8'((k % (NI+1) == NI) ? b : w);
    endtask

    task automatic load_random();
        for (int k = 0; k < M; k++) rom[k] = 8'($urandom);
        for (int i = 0; i < NI; i++) x_in[8*i +: 8] = 8'($urandom);
    endtask

    function automatic logic [BW-1:0] fill(input logic [7:0] v);
        logic [BW-1:0] b;
        for (int j = 0; j < NO; j++) b[8*j +: 8] = v;
        return b;
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        for (int k = 0; k < M; k++) rom[k] = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset.busy", BW'(busy0), '0);
        chk("reset.done", BW'(done0), '0);
        chk("reset.valid", BW'(sv0), '0);
        chk("reset.w_en", BW'(w_en0), '0);
        chk("reset.w_addr", BW'(w_addr0), '0);
        chk("reset.scores", scores0, '0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: neuron j weights j+1, bias 0
        for (int k = 0; k < M; k++) rom[k] = 8'((k % (NI+1) == NI) ? 0 : k / (NI+1) + 1);
        x_in = {8'd3, 8'd2, 8'd1};
        do_run(1'b0, 0);
        chk("basic.done_cycle", BW'(done_cyc), BW'(42));
        chk("basic.slot0", BW'(scores0[7:0]), BW'(6));
        chk("basic.slot9", BW'(scores0[79:72]), BW'(60));
        chk("basic.argmax", BW'(argmax(scores0)), BW'(9));
        chk("basic.shift2_slot9", BW'(scores1[79:72]), BW'(15));

        // Negative sums clamp to zero
        load_uniform(-1, 2);
        do_run(1'b0, 0);
        chk("relu.d0", scores0, fill(8'd0));
        chk("relu.d1", scores1, fill(8'd0));

        // Saturation, no accumulator wrap
        load_uniform(127, 127);
        x_in = {8'd255, 8'd255, 8'd255};
        do_run(1'b0, 0);
        chk("sat.d0", scores0, fill(8'd255));
        chk("sat.d1", scores1, fill(8'd255));

        // Shift and bias
        load_uniform(1, 6);
        x_in = {8'd3, 8'd2, 8'd1};
        do_run(1'b0, 0);
        chk("shift.d1", scores1, fill(8'd3));
        chk("shift.d0", scores0, fill(8'd12));

        // Protocol: ignored starts in RUN and DONE
        load_random();
        do_run(1'b1, 0);
        chk("proto.w_en_cycles", BW'(wen_cnt), BW'(M));
        chk("proto.done_cycle", BW'(done_cyc), BW'(42));

        // Reset mid-run, then a clean run
        load_random();
        do_run(1'b0, 17);
        chk("rst_mid.no_done", BW'(done_cyc == -1), BW'(1));
        load_random();
        do_run(1'b0, 0);
        chk("after_rst.done_cycle", BW'(done_cyc), BW'(42));

        for (int n = 0; n < 4; n++) begin
            load_random();
            do_run(1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
